// File: rtl/ras_driver.sv
// Return-address-stack driver: classifies fetched JAL/JALR as call/return,
// predicts their targets and issues push/pop/flush pulses to an external RAS.
module ras_driver #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [31:0]     fetch_inst,
    output logic            fetch_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_pred_taken,
    output logic [XLEN-1:0] out_pred_target,
    output logic            out_is_call,
    output logic            out_is_ret,
    output logic            ras_push,
    output logic            ras_pop,
    output logic            ras_flush,
    output logic [XLEN-1:0] ras_push_addr,
    input  logic [XLEN-1:0] ras_top_addr,
    input  logic            ras_empty,
    output logic [15:0]     overflow_count
);
    localparam int unsigned OCC_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [6:0]  OP_JAL  = 7'b1101111;
    localparam logic [6:0]  OP_JALR = 7'b1100111;

    typedef enum logic {IDLE, PUSH_PEND} state_t;

    state_t           state_q, state_d;
    logic [OCC_W-1:0] occ_q;
    logic [XLEN-1:0]  pend_addr_q;

    logic [4:0]       rd, rs1;
    logic             rd_link, rs1_link, is_jal, is_jalr;
    logic             dec_call, dec_ret, dec_co, dec_taken;
    logic [20:0]      imm_j;
    logic [XLEN-1:0]  dec_target, link_addr;
    logic             accept;

    // Instruction classification; only opcode, rd and rs1 matter.
    always_comb begin
        rd         = fetch_inst[11:7];
        rs1        = fetch_inst[19:15];
        is_jal     = fetch_inst[6:0] == OP_JAL;
        is_jalr    = fetch_inst[6:0] == OP_JALR;
        rd_link    = (rd == 5'd1) || (rd == 5'd5);
        rs1_link   = (rs1 == 5'd1) || (rs1 == 5'd5);
        imm_j      = {fetch_inst[31], fetch_inst[19:12], fetch_inst[20], fetch_inst[30:21], 1'b0};
        link_addr  = fetch_pc + XLEN'(4);
        dec_call   = (is_jal || is_jalr) && rd_link;
        dec_ret    = is_jalr && rs1_link && (!rd_link || (rd != rs1));
        dec_co     = dec_call && dec_ret;
        dec_taken  = is_jal || (dec_ret && !ras_empty);
        dec_target = '0;
        if (is_jal) begin
            dec_target = fetch_pc + XLEN'($signed(imm_j));
        end else if (dec_ret && !ras_empty) begin
            dec_target = ras_top_addr;
        end
    end

    // Next state and RAS command pulses; a coroutine's push is deferred one cycle.
    always_comb begin
        state_d       = state_q;
        fetch_ready   = 1'b0;
        accept        = 1'b0;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        ras_flush     = rst || redirect;
        ras_push_addr = link_addr;
        case (state_q)
            IDLE: begin
                fetch_ready = !rst && !redirect && (!out_valid || out_ready);
                accept      = fetch_valid && fetch_ready;
                if (accept) begin
                    ras_push = dec_call && !dec_co;
                    ras_pop  = dec_ret && !ras_empty;
                    if (dec_co) begin
                        state_d = PUSH_PEND;
                    end
                end
            end
            PUSH_PEND: begin
                ras_push      = !rst && !redirect;
                ras_push_addr = pend_addr_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && dec_co) begin
                pend_addr_q <= link_addr;
            end
        end
    end

    // Prediction record: loads on accept, drains on out_ready, dropped by redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_inst        <= '0;
            out_pred_taken  <= 1'b0;
            out_pred_target <= '0;
            out_is_call     <= 1'b0;
            out_is_ret      <= 1'b0;
        end else if (redirect) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_pc          <= fetch_pc;
            out_inst        <= fetch_inst;
            out_pred_taken  <= dec_taken;
            out_pred_target <= dec_target;
            out_is_call     <= dec_call;
            out_is_ret      <= dec_ret;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Occupancy mirror of the RAS; pushes beyond full are counted, not blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q          <= '0;
            overflow_count <= '0;
        end else if (redirect) begin
            occ_q <= '0;
        end else if (ras_push) begin
            if (occ_q == OCC_W'(RAS_DEPTH)) begin
                if (overflow_count != 16'hFFFF) begin
                    overflow_count <= overflow_count + 16'd1;
                end
            end else begin
                occ_q <= occ_q + OCC_W'(1);
            end
        end else if (ras_pop && (occ_q != '0)) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end
endmodule

// File: doc/ras_driver.md
RAS_DRIVER -- requirements
Module: ras_driver

Interface
REQ-001 Parameter XLEN, default 32, datapath and address width.
REQ-002 Parameter RAS_DEPTH, default 8, entry count of the attached return address stack; mirrored by the occupancy counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 redirect  input  1  mispredict/redirect from backend; flushes driver and RAS.
REQ-006 fetch_valid  input  1  fetch slot holds an instruction.
REQ-007 fetch_pc  input  XLEN  PC of fetch slot.
REQ-008 fetch_inst  input  32  RV32 instruction word.
REQ-009 fetch_ready  output  1  driver accepts fetch slot this cycle.
REQ-010 out_valid  output  1  registered prediction record valid.
REQ-011 out_ready  input  1  decode consumes record.
REQ-012 out_pc, out_inst  output  XLEN, 32  registered copies of accepted slot.
REQ-013 out_pred_taken  output  1  control transfer predicted taken.
REQ-014 out_pred_target  output  XLEN  predicted target; 0 when not taken.
REQ-015 out_is_call, out_is_ret  output  1 each  classification of accepted slot.
REQ-016 ras_push, ras_pop, ras_flush  output  1 each  one-cycle command pulses to RAS.
REQ-017 ras_push_addr  output  XLEN  return address to push.
REQ-018 ras_top_addr, ras_empty  input  XLEN, 1  current RAS top and empty flag.
REQ-019 overflow_count  output  16  saturating count of pushes issued at full occupancy.

Function
REQ-020 Link register = x1 or x5; classification uses opcode, rd, rs1 only.
REQ-021 JAL with rd link: call, push pc+4; JAL any rd: taken, target pc+sext(imm_j).
REQ-022 JALR rd link, rs1 not link: call, push pc+4, pred_taken 0.
REQ-023 JALR rd not link, rs1 link: ret; pop and target ras_top_addr when !ras_empty; ras_empty -> no pop, pred_taken 0.
REQ-024 JALR rd and rs1 link, rd==rs1: call only (push pc+4).
REQ-025 JALR rd and rs1 link, rd!=rs1 (coroutine): ret then call; pop in accept cycle, push pc+4 in next cycle via PUSH_PEND (ret rules of REQ-023 apply; push always issued).
REQ-026 All other instructions: not call, not ret, not taken, no RAS commands.
REQ-027 FSM states IDLE, PUSH_PEND; IDLE -> PUSH_PEND on coroutine accept; PUSH_PEND -> IDLE unconditionally next cycle, asserting ras_push with stored pc+4.
REQ-028 fetch_ready = state IDLE AND !redirect AND (!out_valid OR out_ready).
REQ-029 Accept = fetch_valid AND fetch_ready; ras_push/ras_pop asserted combinationally only in accept cycle (or PUSH_PEND); never both in one cycle.
REQ-030 Output record loads on accept edge (latency 1); out_valid clears on out_ready without accept; held stable while out_valid AND !out_ready.
REQ-031 Occupancy counter 0..RAS_DEPTH: +1 on push (saturate at RAS_DEPTH), -1 on pop (floor 0).
REQ-032 Push at occupancy RAS_DEPTH: command still issued, overflow_count +1 saturating at 0xFFFF.
REQ-033 redirect: ras_flush=1 same cycle, no push/pop, next edge state IDLE, out_valid 0, occupancy 0; overflow_count retained; overrides PUSH_PEND (pending push dropped).
REQ-034 Target arithmetic modulo 2^XLEN; wrap-around not flagged.

Reset
REQ-035 On rst: state IDLE, out_valid 0, out_pc/out_inst/out_pred_target 0, out_pred_taken/out_is_call/out_is_ret 0, occupancy 0, overflow_count 0.
REQ-036 During rst: ras_flush=1, ras_push=ras_pop=0, fetch_ready=0; reset mid-PUSH_PEND drops pending push.

Verification
REQ-037 JAL x1,+0x40 at pc 0x100 -> ras_push=1, ras_push_addr 0x104; next cycle out_pred_taken 1, target 0x140, out_is_call 1.
REQ-038 JALR x0,0(x1) at 0x300, ras_top_addr 0x104, ras_empty 0 -> ras_pop=1; out target 0x104, taken 1, is_ret 1.
REQ-039 Same ret with ras_empty 1 -> no pop; out_pred_taken 0, target 0, is_ret 1.
REQ-040 JALR x5,0(x1) at 0x200 -> cycle N pop; N+1 fetch_ready 0, push 0x204; N+2 fetch_ready 1.
REQ-041 Coroutine accepted, redirect in PUSH_PEND -> ras_flush 1, no push, out_valid 0, state IDLE next cycle.
REQ-042 Nine JAL x1 back-to-back, RAS_DEPTH 8, out_ready 1 -> ninth push issued, overflow_count 1; out_ready 0 with out_valid 1 -> fetch_ready 0, no RAS commands, record stable.
